// File: rtl/ifm_pingpong_buf.sv
// ifm_pingpong_buf
//   Ping-pong input-feature-map buffer between the S2/K2 average-pool stage
//   and the next convolution stage. The pool writes the bank selected by
//   ifm_sel. The consumer reads the opposite bank through two independent
//   read ports, A and B. Per-bank full flags record which bank holds a
//   finished map. Writing (or completing) a bank that is still full raises a
//   sticky overflow_err.
//
// Ports
//   clk                 clock
//   reset               synchronous, active-high reset
//   ifm_sel             0: write bank0 / read bank1, 1: write bank1 / read bank0
//   ifm_enable_write    write strobe
//   ifm_address_write   write address
//   data_in             write data
//   start_from_previous pulse: current write bank is complete
//   end_from_next       pulse: consumer finished its read bank
//   ifm_enable_read_A/B read strobes
//   ifm_address_read_A/B read addresses
//   data_out_A/B        registered read data
//   bank_full           bit b set: bank b holds an unconsumed map
//   overflow_err        sticky error flag, cleared only by reset
//
// Configuration
//   IFM_BUF_OUTREG_EN   when defined, adds a second output register stage,
//                       making the read latency 2 cycles instead of 1.

module ifm_pingpong_buf #(
  parameter int DATA_WIDTH   = 32,
  parameter int IFM_SIZE     = 14,
  parameter int IFM_DEPTH    = 6,
  parameter int ADDRESS_SIZE = $clog2(IFM_SIZE * IFM_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ifm_sel,
  input  logic                    ifm_enable_write,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_write,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    start_from_previous,
  input  logic                    end_from_next,
  input  logic                    ifm_enable_read_A,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_read_A,
  input  logic                    ifm_enable_read_B,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_read_B,
  output logic [DATA_WIDTH-1:0]   data_out_A,
  output logic [DATA_WIDTH-1:0]   data_out_B,
  output logic [1:0]              bank_full,
  output logic                    overflow_err
);

  localparam int unsigned DEPTH = IFM_SIZE * IFM_SIZE;

  // Channel packing inside a word is opaque here; the parameter is kept so
  // the instance matches the rest of the pipeline.
  logic [31:0] depth_unused;
  assign depth_unused = 32'(IFM_DEPTH);

  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];

  logic                  wr_in_range;
  logic                  rd_a_in_range;
  logic                  rd_b_in_range;
  logic                  wr_bank_full;
  logic                  wr_en;
  logic                  overflow_hit;
  logic [1:0]            bank_full_next;
  logic [DATA_WIDTH-1:0] rd_a_word;
  logic [DATA_WIDTH-1:0] rd_b_word;

  // Address checks, write qualification and the read mux. The read bank is
  // always the one not being written, so reads never collide with writes.
  always_comb begin
    wr_in_range   = 32'(ifm_address_write)  < DEPTH;
    rd_a_in_range = 32'(ifm_address_read_A) < DEPTH;
    rd_b_in_range = 32'(ifm_address_read_B) < DEPTH;
    wr_bank_full  = bank_full[ifm_sel];
    wr_en         = ifm_enable_write && wr_in_range && !wr_bank_full && !reset;
    overflow_hit  = wr_bank_full && (ifm_enable_write || start_from_previous);

    rd_a_word = '0;
    if (rd_a_in_range) begin
      rd_a_word = ifm_sel ? bank0[ifm_address_read_A] : bank1[ifm_address_read_A];
    end
    rd_b_word = '0;
    if (rd_b_in_range) begin
      rd_b_word = ifm_sel ? bank0[ifm_address_read_B] : bank1[ifm_address_read_B];
    end

    // start and end always target different banks, so both can apply at once.
    bank_full_next = bank_full;
    if (start_from_previous) begin
      bank_full_next[ifm_sel] = 1'b1;
    end
    if (end_from_next) begin
      bank_full_next[~ifm_sel] = 1'b0;
    end
  end

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (ifm_sel) begin
        bank1[ifm_address_write] <= data_in;
      end else begin
        bank0[ifm_address_write] <= data_in;
      end
    end
  end

  // Bank flags and the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full    <= 2'b00;
      overflow_err <= 1'b0;
    end else begin
      bank_full <= bank_full_next;
      if (overflow_hit) begin
        overflow_err <= 1'b1;
      end
    end
  end

`ifdef IFM_BUF_OUTREG_EN
  logic [DATA_WIDTH-1:0] stage_a;
  logic [DATA_WIDTH-1:0] stage_b;
  logic                  en_a_d;
  logic                  en_b_d;

  // Two-stage output: stage 1 captures the RAM word, stage 2 loads only when
  // the delayed enable shows stage 1 was refreshed on the previous edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_a    <= '0;
      stage_b    <= '0;
      en_a_d     <= 1'b0;
      en_b_d     <= 1'b0;
      data_out_A <= '0;
      data_out_B <= '0;
    end else begin
      en_a_d <= ifm_enable_read_A;
      en_b_d <= ifm_enable_read_B;
      if (ifm_enable_read_A) begin
        stage_a <= rd_a_word;
      end
      if (ifm_enable_read_B) begin
        stage_b <= rd_b_word;
      end
      if (en_a_d) begin
        data_out_A <= stage_a;
      end
      if (en_b_d) begin
        data_out_B <= stage_b;
      end
    end
  end
`else
  // Single output stage; each port holds its last word while not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_A <= '0;
      data_out_B <= '0;
    end else begin
      if (ifm_enable_read_A) begin
        data_out_A <= rd_a_word;
      end
      if (ifm_enable_read_B) begin
        data_out_B <= rd_b_word;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifm_pingpong_buf.sv
// tb_ifm_pingpong_buf
//   Directed self-checking bench for ifm_pingpong_buf with default parameters
//   (32-bit words, 14x14 map, 196-deep banks, 8-bit addresses).

module tb_ifm_pingpong_buf;

  localparam int DW = 32;
  localparam int AS = 8;
`ifdef IFM_BUF_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ifm_sel;
  logic          ifm_enable_write;
  logic [AS-1:0] ifm_address_write;
  logic [DW-1:0] data_in;
  logic          start_from_previous;
  logic          end_from_next;
  logic          ifm_enable_read_A;
  logic [AS-1:0] ifm_address_read_A;
  logic          ifm_enable_read_B;
  logic [AS-1:0] ifm_address_read_B;
  logic [DW-1:0] data_out_A;
  logic [DW-1:0] data_out_B;
  logic [1:0]    bank_full;
  logic          overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  ifm_pingpong_buf dut (
    .clk                 (clk),
    .reset               (reset),
    .ifm_sel             (ifm_sel),
    .ifm_enable_write    (ifm_enable_write),
    .ifm_address_write   (ifm_address_write),
    .data_in             (data_in),
    .start_from_previous (start_from_previous),
    .end_from_next       (end_from_next),
    .ifm_enable_read_A   (ifm_enable_read_A),
    .ifm_address_read_A  (ifm_address_read_A),
    .ifm_enable_read_B   (ifm_enable_read_B),
    .ifm_address_read_B  (ifm_address_read_B),
    .data_out_A          (data_out_A),
    .data_out_B          (data_out_B),
    .bank_full           (bank_full),
    .overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle read pulse on both ports, then wait out the read latency.
  task automatic do_read(input logic [AS-1:0] a, input logic [AS-1:0] b);
    ifm_enable_read_A  = 1'b1;
    ifm_address_read_A = a;
    ifm_enable_read_B  = 1'b1;
    ifm_address_read_B = b;
    tick();
    ifm_enable_read_A = 1'b0;
    ifm_enable_read_B = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic do_write(input logic [AS-1:0] addr, input logic [DW-1:0] d);
    ifm_enable_write  = 1'b1;
    ifm_address_write = addr;
    data_in           = d;
    tick();
    ifm_enable_write = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    ifm_enable_read_A  = 1'b1;
    ifm_enable_read_B  = 1'b1;
    ifm_address_read_A = '0;
    ifm_address_read_B = '0;
    tick();
    tick();
    n_checks++;
    if (data_out_A !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_data_out_A: got %h expected %h", data_out_A, 32'h0);
    end
    n_checks++;
    if (data_out_B !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_data_out_B: got %h expected %h", data_out_B, 32'h0);
    end
    n_checks++;
    if (bank_full !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL reset_bank_full: got %b expected %b", bank_full, 2'b00);
    end
    n_checks++;
    if (overflow_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_overflow_err: got %b expected %b", overflow_err, 1'b0);
    end
    ifm_enable_read_A = 1'b0;
    ifm_enable_read_B = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_and_read();
    ifm_sel = 1'b0;
    for (int k = 0; k < 196; k++) begin
      do_write(AS'(k), 32'h100 + 32'(k));
    end
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    ifm_sel = 1'b1;
    n_checks++;
    if (bank_full !== 2'b01) begin
      n_errors++;
      $display("[TB] FAIL fill_bank_full: got %b expected %b", bank_full, 2'b01);
    end
    n_checks++;
    if (overflow_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL fill_overflow_err: got %b expected %b", overflow_err, 1'b0);
    end
    do_read(8'd5, 8'd195);
    n_checks++;
    if (data_out_A !== 32'h105) begin
      n_errors++;
      $display("[TB] FAIL read_A_addr5: got %h expected %h", data_out_A, 32'h105);
    end
    n_checks++;
    if (data_out_B !== 32'h1C3) begin
      n_errors++;
      $display("[TB] FAIL read_B_addr195: got %h expected %h", data_out_B, 32'h1C3);
    end
    // Changing addresses with enables low must not disturb the outputs.
    ifm_address_read_A = 8'd0;
    ifm_address_read_B = 8'd1;
    repeat (3) tick();
    n_checks++;
    if (data_out_A !== 32'h105 || data_out_B !== 32'h1C3) begin
      n_errors++;
      $display("[TB] FAIL hold_outputs: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h105, 32'h1C3);
    end
    do_read(8'd10, 8'd10);
    n_checks++;
    if (data_out_A !== 32'h10A || data_out_B !== 32'h10A) begin
      n_errors++;
      $display("[TB] FAIL same_addr_AB: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h10A, 32'h10A);
    end
  endtask

  task automatic test_overflow();
    ifm_sel = 1'b0;
    do_write(8'd5, 32'hDEAD);
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL overflow_set: got %b expected %b", overflow_err, 1'b1);
    end
    ifm_sel = 1'b1;
    do_read(8'd5, 8'd6);
    n_checks++;
    if (data_out_A !== 32'h105 || data_out_B !== 32'h106) begin
      n_errors++;
      $display("[TB] FAIL overflow_blocked_write: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h105, 32'h106);
    end
    n_checks++;
    if (bank_full !== 2'b01) begin
      n_errors++;
      $display("[TB] FAIL overflow_bank_full: got %b expected %b", bank_full, 2'b01);
    end
  endtask

  task automatic test_out_of_range();
    ifm_sel = 1'b1;
    do_write(8'd4, 32'h44);
    do_write(8'd195, 32'h1195);
    do_write(8'd200, 32'hBEEF);
    do_read(8'd200, 8'd195);
    n_checks++;
    if (data_out_A !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL oor_read_A: got %h expected %h", data_out_A, 32'h0);
    end
    n_checks++;
    if (data_out_B !== 32'h1C3) begin
      n_errors++;
      $display("[TB] FAIL oor_neighbour_B: got %h expected %h", data_out_B, 32'h1C3);
    end
    ifm_sel = 1'b0;
    do_read(8'd4, 8'd195);
    n_checks++;
    if (data_out_A !== 32'h44 || data_out_B !== 32'h1195) begin
      n_errors++;
      $display("[TB] FAIL oor_write_no_alias: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h44, 32'h1195);
    end
    do_read(8'd4, 8'd255);
    n_checks++;
    if (data_out_B !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL oor_read_B255: got %h expected %h", data_out_B, 32'h0);
    end
  endtask

  task automatic test_simultaneous_flags();
    ifm_sel = 1'b1;
    start_from_previous = 1'b1;
    end_from_next       = 1'b1;
    tick();
    start_from_previous = 1'b0;
    end_from_next       = 1'b0;
    n_checks++;
    if (bank_full !== 2'b10) begin
      n_errors++;
      $display("[TB] FAIL start_and_end: got %b expected %b", bank_full, 2'b10);
    end
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    n_checks++;
    if (bank_full !== 2'b10) begin
      n_errors++;
      $display("[TB] FAIL end_on_empty: got %b expected %b", bank_full, 2'b10);
    end
    ifm_sel = 1'b0;
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    n_checks++;
    if (bank_full !== 2'b11) begin
      n_errors++;
      $display("[TB] FAIL both_full: got %b expected %b", bank_full, 2'b11);
    end
  endtask

  task automatic test_reset_mid();
    ifm_enable_read_A  = 1'b1;
    ifm_address_read_A = 8'd5;
    ifm_enable_read_B  = 1'b1;
    ifm_address_read_B = 8'd6;
    reset = 1'b1;
    tick();
    n_checks++;
    if (bank_full !== 2'b00 || overflow_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL midreset_flags: got %b/%b expected %b/%b",
               bank_full, overflow_err, 2'b00, 1'b0);
    end
    n_checks++;
    if (data_out_A !== 32'h0 || data_out_B !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL midreset_outputs: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h0, 32'h0);
    end
    ifm_enable_read_A = 1'b0;
    ifm_enable_read_B = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (data_out_A !== 32'h0 || data_out_B !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL midreset_dropped_read: got %h/%h expected %h/%h",
               data_out_A, data_out_B, 32'h0, 32'h0);
    end
  endtask

  task automatic test_start_on_full();
    ifm_sel = 1'b0;
    start_from_previous = 1'b1;
    tick();
    n_checks++;
    if (bank_full !== 2'b01 || overflow_err !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL first_start: got %b/%b expected %b/%b",
               bank_full, overflow_err, 2'b01, 1'b0);
    end
    tick();
    start_from_previous = 1'b0;
    n_checks++;
    if (bank_full !== 2'b01 || overflow_err !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL start_on_full: got %b/%b expected %b/%b",
               bank_full, overflow_err, 2'b01, 1'b1);
    end
  endtask

  initial begin
    reset               = 1'b1;
    ifm_sel             = 1'b0;
    ifm_enable_write    = 1'b0;
    ifm_address_write   = '0;
    data_in             = '0;
    start_from_previous = 1'b0;
    end_from_next       = 1'b0;
    ifm_enable_read_A   = 1'b0;
    ifm_address_read_A  = '0;
    ifm_enable_read_B   = 1'b0;
    ifm_address_read_B  = '0;

    test_reset();
    test_fill_and_read();
    test_overflow();
    test_out_of_range();
    test_simultaneous_flags();
    test_reset_mid();
    test_start_on_full();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
